bcd_addsub_seq: RTL and testbench

//  Digit-serial, sign-magnitude BCD adder/subtractor for NDIGITS-digit operands. Processes one

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_addsub_seq_if.sv | 29 ++
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_addsub_seq.sv | 173 +++++++++++++++++
 tb/tb_bcd_addsub_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and digit helpers for the digit-serial BCD add/subtract datapath.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
   localparam logic [STATE_W-1:0] ST_ADD   = 3'd2;
   localparam logic [STATE_W-1:0] ST_FIX   = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
      return DIGIT_W'(9) - d;
   endfunction

   function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/bcd_addsub_seq_if.sv
// Request/result bundle for the sequential BCD adder/subtractor.
interface bcd_addsub_seq_if #(parameter int unsigned NDIGITS = 4);

   localparam int unsigned W = 4 * NDIGITS;

   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic         a_sign;
   logic [W-1:0] b;
   logic         b_sign;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         r_sign;
   logic         ovf;
   logic         err;

   modport master (
      output start, op, a, a_sign, b, b_sign,
      input  busy, done, result, r_sign, ovf, err
   );

   modport slave (
      input  start, op, a, a_sign, b, b_sign,
      output busy, done, result, r_sign, ovf, err
   );

endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal (+6) correction; shared by the add and recomplement passes.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   localparam int unsigned SUM_W = DIGIT_W + 1;

   logic [SUM_W-1:0] raw;
   logic [SUM_W-1:0] adj;

   always_comb begin
      raw  = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
      cout = raw > SUM_W'(9);
      adj  = cout ? raw + SUM_W'(6) : raw;
      s    = adj[DIGIT_W-1:0];
   end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial sign-magnitude BCD adder/subtractor, LSD first, with ten's-complement fix-up pass.
module bcd_addsub_seq
   import bcd_pkg::*;
#(
   parameter int unsigned NDIGITS = 4
)(
   input  logic            clk,
   input  logic            rst,
   bcd_addsub_seq_if.slave bus
);

   localparam int unsigned W     = DIGIT_W * NDIGITS;
   localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [STATE_W-1:0] state_q, state_n;
   logic [IDX_W-1:0]   idx_q, idx_n;
   logic               carry_q, carry_n;
   logic [W-1:0]       a_q, a_n, b_q, b_n, res_q, res_n;
   logic               a_sign_q, a_sign_n, sub_q, sub_n;
   logic               r_sign_q, r_sign_n, ovf_q, ovf_n, err_q, err_n;
   logic               busy_q, busy_n, done_q, done_n;

   int unsigned        pos;
   logic               last, bad;
   logic [DIGIT_W-1:0] add_x, add_y, add_s;
   logic               add_cin, add_cout;

   bcd_digit_add u_digit (
      .a    (add_x),
      .b    (add_y),
      .cin  (add_cin),
      .s    (add_s),
      .cout (add_cout)
   );

   // Next-state and next-register logic
   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      carry_n  = carry_q;
      a_n      = a_q;
      b_n      = b_q;
      a_sign_n = a_sign_q;
      sub_n    = sub_q;
      res_n    = res_q;
      r_sign_n = r_sign_q;
      ovf_n    = ovf_q;
      err_n    = err_q;

      pos  = DIGIT_W * 32'(idx_q);
      last = (idx_q == IDX_W'(NDIGITS - 1));

      bad = 1'b0;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
         if (!digit_valid(a_q[i*DIGIT_W +: DIGIT_W]) || !digit_valid(b_q[i*DIGIT_W +: DIGIT_W]))
            bad = 1'b1;
      end

      // FIX recomplements the stored result; ADD combines A with B or its nines' complement
      add_cin = carry_q;
      if (state_q == ST_FIX) begin
         add_x = nines_comp(res_q[pos +: DIGIT_W]);
         add_y = '0;
      end else begin
         add_x = a_q[pos +: DIGIT_W];
         add_y = sub_q ? nines_comp(b_q[pos +: DIGIT_W]) : b_q[pos +: DIGIT_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_n      = bus.a;
               b_n      = bus.b;
               a_sign_n = bus.a_sign;
               sub_n    = bus.a_sign ^ bus.b_sign ^ bus.op;
               res_n    = '0;
               r_sign_n = 1'b0;
               ovf_n    = 1'b0;
               err_n    = 1'b0;
               state_n  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            idx_n   = '0;
            carry_n = sub_q;
            if (bad) begin
               err_n   = 1'b1;
               state_n = ST_DONE;
            end else begin
               state_n = ST_ADD;
            end
         end
         ST_ADD: begin
            res_n[pos +: DIGIT_W] = add_s;
            carry_n               = add_cout;
            idx_n                 = idx_q + IDX_W'(1);
            if (last) begin
               idx_n = '0;
               if (!sub_q) begin
                  ovf_n    = add_cout;
                  r_sign_n = a_sign_q;
                  state_n  = ST_DONE;
               end else if (add_cout) begin
                  r_sign_n = a_sign_q;
                  state_n  = ST_DONE;
               end else begin
                  r_sign_n = ~a_sign_q;
                  carry_n  = 1'b1;
                  state_n  = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            res_n[pos +: DIGIT_W] = add_s;
            carry_n               = add_cout;
            idx_n                 = idx_q + IDX_W'(1);
            if (last) begin
               idx_n   = '0;
               state_n = ST_DONE;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      // No negative zero
      if (state_n == ST_DONE && res_n == '0)
         r_sign_n = 1'b0;

      busy_n = (state_n != ST_IDLE);
      done_n = (state_n == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         a_sign_q <= 1'b0;
         sub_q    <= 1'b0;
         res_q    <= '0;
         r_sign_q <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         idx_q    <= idx_n;
         carry_q  <= carry_n;
         a_q      <= a_n;
         b_q      <= b_n;
         a_sign_q <= a_sign_n;
         sub_q    <= sub_n;
         res_q    <= res_n;
         r_sign_q <= r_sign_n;
         ovf_q    <= ovf_n;
         err_q    <= err_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.r_sign = r_sign_q;
   assign bus.ovf    = ovf_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq: directed vectors, monitor pops expectations on each done pulse.
module tb_bcd_addsub_seq;

   localparam int unsigned NDIGITS = 4;
   localparam int unsigned W       = 4 * NDIGITS;

   typedef struct {
      logic [W-1:0] result;
      logic         r_sign;
      logic         ovf;
      logic         err;
      int           start_cyc;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_addsub_seq_if #(.NDIGITS(NDIGITS)) bus ();

   bcd_addsub_seq #(.NDIGITS(NDIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, required no pending op (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", bus.result, e.result);
            check("r_sign", W'(bus.r_sign), W'(e.r_sign));
            check("ovf", W'(bus.ovf), W'(e.ovf));
            check("err", W'(bus.err), W'(e.err));
            check("busy_in_done", W'(bus.busy), W'(1'b1));
            check_int("latency", cyc - e.start_cyc, e.lat);
         end
      end
   end

   // Waits for idle, pulses start for one cycle, optionally queues the expected response
   task automatic issue(input logic [W-1:0] a, input logic as, input logic [W-1:0] b,
                        input logic bs, input logic op, input logic push,
                        input logic [W-1:0] er, input logic es, input logic eo,
                        input logic ee, input int lat);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", bus.busy, n);
      end
      bus.a      = a;
      bus.a_sign = as;
      bus.b      = b;
      bus.b_sign = bs;
      bus.op     = op;
      bus.start  = 1'b1;
      if (push) begin
         e.result    = er;
         e.r_sign    = es;
         e.ovf       = eo;
         e.err       = ee;
         e.start_cyc = cyc + 1;
         e.lat       = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", W'(bus.busy), W'(1'b1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_int("drain_pending", sb.size(), 0);
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 1'b0;
      bus.a      = '0;
      bus.a_sign = 1'b0;
      bus.b      = '0;
      bus.b_sign = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", W'(bus.busy), '0);
      check("rst_done", W'(bus.done), '0);
      check("rst_result", bus.result, '0);
      check("rst_r_sign", W'(bus.r_sign), '0);
      check("rst_ovf", W'(bus.ovf), '0);
      check("rst_err", W'(bus.err), '0);
      rst = 1'b0;

      // 1234 + 5678
      issue(16'h1234, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
      // invalid digit in A: result clears on acceptance, err after one cycle
      issue(16'h12A4, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
      check("clear_on_accept", bus.result, '0);
      // 0500 - 1234 via recomplement; err cleared at acceptance
      issue(16'h0500, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0734, 1'b1, 1'b0, 1'b0, 9);
      check("err_cleared", W'(bus.err), '0);
      // 9999 + 0001 overflows
      issue(16'h9999, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 5);
      // -42 + 42 gives positive zero
      issue(16'h0042, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
      // -3 - (-5) = +2 through the fix pass
      issue(16'h0003, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 9);
      // 7 + (-3) = 4
      issue(16'h0007, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 5);
      // start while busy must be ignored
      @(negedge clk);
      bus.a     = 16'h9999;
      bus.b     = 16'h9999;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      // -5000 + -6000 overflows, negative
      issue(16'h5000, 1'b1, 16'h6000, 1'b1, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b1, 1'b0, 5);
      // invalid digit in B
      issue(16'h0001, 1'b0, 16'h00F0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
      drain();

      // reset during the third ADD cycle aborts without done
      issue(16'h1234, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", W'(bus.busy), '0);
      check("abort_done", W'(bus.done), '0);
      check("abort_result", bus.result, '0);
      check("abort_r_sign", W'(bus.r_sign), '0);
      check("abort_ovf", W'(bus.ovf), '0);
      check("abort_err", W'(bus.err), '0);
      repeat (20) @(negedge clk);

      // operation after abort works normally
      issue(16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 5);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
